calibration_sequencer_accum: RTL and testbench

- Autonomous multi-pass LED calibration sequencer.
- On one start event it steps through all ID_BITS bit-planes, MSB first.
- For each bit-plane it handshakes with the LED pattern driver, waits SETTLE_FRAMES camera frames, then captures one frame of detector decisions into an internal per-pixel accumulator.
- Sits between the camera detect pipeline (hcount/vcount/detect) and the LED strand driver. A separate read port lets downstream logic fetch decoded LED IDs per downsampled pixel.

---
 rtl/calibration_sequencer_accum.sv | 213 +++++++++++++++++++++
 tb/tb_calibration_sequencer_accum.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_sequencer_accum.sv
// Multi-pass LED calibration sequencer: sweeps the LED ID bit-planes MSB first and
// builds a per-pixel {valid, id} accumulator from one captured frame per bit-plane.
//
// state   | meaning
// IDLE    | waiting for a start_in rising edge
// REQ     | pattern_req_out high, waiting for pattern_ack_in
// SETTLE  | skipping SETTLE_FRAMES whole frames after the ack
// CAPTURE | accumulating one frame of detector decisions
module calibration_sequencer_accum #(
    parameter int ID_BITS         = 10,
    parameter int SETTLE_FRAMES   = 2,
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int DS_SHIFT        = 2,
    localparam int DEPTH = (ACTIVE_H_PIXELS >> DS_SHIFT) * (ACTIVE_LINES >> DS_SHIFT),
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = $clog2(ID_BITS)
) (
    input  logic               clk_pixel,
    input  logic               rst,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic               pattern_ack_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               new_frame_in,
    input  logic               detect_0,
    input  logic               detect_1,
    input  logic [AW-1:0]      rd_addr_in,
    input  logic               rd_req_in,
    output logic               pattern_req_out,
    output logic [BW-1:0]      bit_index_out,
    output logic [2:0]         state_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               result_ready_out,
    output logic [AW:0]        conflict_count_out,
    output logic [ID_BITS-1:0] rd_data_out,
    output logic               rd_pix_valid_out,
    output logic               rd_valid_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3
    } state_t;

    localparam int          SW      = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);
    localparam int          H_DS    = ACTIVE_H_PIXELS >> DS_SHIFT;
    localparam logic [AW:0] CNT_MAX = '1;
    localparam logic [AW:0] CNT_ONE = 1;

    state_t            state_q;
    logic [BW-1:0]     bit_idx_q;
    logic [SW-1:0]     settle_cnt_q;
    logic              start_prev_q;
    logic              done_q;
    logic              result_ready_q;
    logic [AW:0]       pass_cnt_q;
    logic [AW:0]       conflict_count_q;

    logic [ID_BITS:0]  mem [DEPTH];
    logic              p1_v_q, p1_d1_q, p1_conf_q, p1_first_q;
    logic [AW-1:0]     p1_addr_q;
    logic [ID_BITS-1:0] a_keep_q;
    logic              p2_v_q;
    logic [AW-1:0]     p2_addr_q;
    logic [ID_BITS:0]  p2_wdata_q;
    logic [ID_BITS:0]  b_word_q;
    logic              rd_stage_q;
    logic              rd_valid_q;
    logic              rd_pix_valid_q;
    logic [ID_BITS-1:0] rd_data_q;

    logic              start_edge;
    logic              settle_done;
    logic              capture_en;
    logic              pixel_hit;
    logic              sample_en;
    logic              conflict;
    logic              first_pass;
    logic [AW-1:0]     sample_addr;

    assign start_edge  = start_in & ~start_prev_q;
    assign settle_done = (state_q == SETTLE) && new_frame_in &&
                         (settle_cnt_q == SW'(SETTLE_FRAMES));
    // A sample landing on a frame-start cycle belongs to the state being entered.
    assign capture_en  = !abort_in &&
                         (settle_done || ((state_q == CAPTURE) && !new_frame_in));
    assign pixel_hit   = (32'(hcount_in) < ACTIVE_H_PIXELS) &&
                         (32'(vcount_in) < ACTIVE_LINES) &&
                         (hcount_in[DS_SHIFT-1:0] == '0) &&
                         (vcount_in[DS_SHIFT-1:0] == '0);
    assign sample_en   = capture_en && pixel_hit;
    assign conflict    = ~(detect_0 ^ detect_1);
    assign first_pass  = (bit_idx_q == BW'(ID_BITS - 1));
    assign sample_addr = AW'(32'(hcount_in >> DS_SHIFT) +
                             32'(H_DS) * 32'(vcount_in >> DS_SHIFT));

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q          <= IDLE;
            bit_idx_q        <= '0;
            settle_cnt_q     <= '0;
            start_prev_q     <= 1'b0;
            done_q           <= 1'b0;
            result_ready_q   <= 1'b0;
            pass_cnt_q       <= '0;
            conflict_count_q <= '0;
        end else begin
            start_prev_q <= start_in;
            done_q       <= 1'b0;
            if (sample_en && conflict && (pass_cnt_q != CNT_MAX)) begin
                pass_cnt_q <= pass_cnt_q + CNT_ONE;
            end
            if (abort_in && (state_q != IDLE)) begin
                state_q    <= IDLE;
                pass_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_edge) begin
                            state_q        <= REQ;
                            bit_idx_q      <= BW'(ID_BITS - 1);
                            result_ready_q <= 1'b0;
                            settle_cnt_q   <= '0;
                            pass_cnt_q     <= '0;
                        end
                    end
                    REQ: begin
                        if (pattern_ack_in) begin
                            state_q      <= SETTLE;
                            settle_cnt_q <= '0;
                        end
                    end
                    SETTLE: begin
                        if (settle_done) begin
                            state_q <= CAPTURE;
                        end else if (new_frame_in) begin
                            settle_cnt_q <= settle_cnt_q + SW'(1);
                        end
                    end
                    CAPTURE: begin
                        if (new_frame_in) begin
                            conflict_count_q <= pass_cnt_q;
                            pass_cnt_q       <= '0;
                            if (bit_idx_q == '0) begin
                                state_q        <= IDLE;
                                done_q         <= 1'b1;
                                result_ready_q <= 1'b1;
                            end else begin
                                bit_idx_q <= bit_idx_q - BW'(1);
                                state_q   <= REQ;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            p1_v_q         <= 1'b0;
            p2_v_q         <= 1'b0;
            rd_stage_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_pix_valid_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            p1_v_q     <= sample_en;
            p2_v_q     <= p1_v_q;
            rd_stage_q <= rd_req_in;
            rd_valid_q <= rd_stage_q;
            if (rd_stage_q) begin
                rd_data_q      <= b_word_q[ID_BITS-1:0];
                rd_pix_valid_q <= b_word_q[ID_BITS];
            end
        end
    end

    // Port A: read in the sample cycle, merge next cycle, write the cycle after.
    always_ff @(posedge clk_pixel) begin
        p1_addr_q  <= sample_addr;
        p1_d1_q    <= detect_1;
        p1_conf_q  <= conflict;
        p1_first_q <= first_pass;
        a_keep_q   <= {mem[sample_addr][ID_BITS], mem[sample_addr][ID_BITS-2:0]};
        p2_addr_q  <= p1_addr_q;
        p2_wdata_q <= p1_first_q ?
                      {~p1_conf_q, {(ID_BITS - 1){1'b0}}, p1_d1_q} :
                      {a_keep_q[ID_BITS-1] & ~p1_conf_q, a_keep_q[ID_BITS-2:0], p1_d1_q};
        if (p2_v_q) begin
            mem[p2_addr_q] <= p2_wdata_q;
        end
        b_word_q <= mem[rd_addr_in];
    end

    assign state_out          = state_q;
    assign bit_index_out      = bit_idx_q;
    assign busy_out           = (state_q != IDLE);
    assign pattern_req_out    = (state_q == REQ);
    assign done_out           = done_q;
    assign result_ready_out   = result_ready_q;
    assign conflict_count_out = conflict_count_q;
    assign rd_data_out        = rd_data_q;
    assign rd_pix_valid_out   = rd_pix_valid_q;
    assign rd_valid_out       = rd_valid_q;

endmodule

// File: tb/tb_calibration_sequencer_accum.sv
// Directed bench for calibration_sequencer_accum on a 16x8 frame, 3-bit IDs;
// a second instance with no settle frames shares the stimulus.
module tb_calibration_sequencer_accum;

    localparam int AW = 3;
    localparam int BW = 2;

    logic          clk_pixel = 1'b0;
    logic          rst = 1'b1;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic          pattern_ack_in = 1'b0;
    logic [10:0]   hcount_in = 11'd16;
    logic [9:0]    vcount_in = 10'd8;
    logic          new_frame_in = 1'b0;
    logic          detect_0 = 1'b0;
    logic          detect_1 = 1'b0;
    logic [AW-1:0] rd_addr_in = '0;
    logic          rd_req_in = 1'b0;

    logic          pattern_req_out, busy_out, done_out, result_ready_out;
    logic [BW-1:0] bit_index_out;
    logic [2:0]    state_out;
    logic [AW:0]   conflict_count_out;
    logic [2:0]    rd_data_out;
    logic          rd_pix_valid_out, rd_valid_out;

    logic          z_pattern_req, z_busy, z_done, z_result_ready;
    logic [BW-1:0] z_bit_index;
    logic [2:0]    z_state;
    logic [AW:0]   z_conflict_count;
    logic [2:0]    z_rd_data;
    logic          z_rd_pix_valid, z_rd_valid;

    int n_vec = 0;
    int n_err = 0;

    calibration_sequencer_accum #(
        .ID_BITS(3), .SETTLE_FRAMES(1), .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(8), .DS_SHIFT(2)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .start_in(start_in), .abort_in(abort_in),
        .pattern_ack_in(pattern_ack_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .new_frame_in(new_frame_in), .detect_0(detect_0), .detect_1(detect_1),
        .rd_addr_in(rd_addr_in), .rd_req_in(rd_req_in),
        .pattern_req_out(pattern_req_out), .bit_index_out(bit_index_out),
        .state_out(state_out), .busy_out(busy_out), .done_out(done_out),
        .result_ready_out(result_ready_out), .conflict_count_out(conflict_count_out),
        .rd_data_out(rd_data_out), .rd_pix_valid_out(rd_pix_valid_out),
        .rd_valid_out(rd_valid_out)
    );

    calibration_sequencer_accum #(
        .ID_BITS(3), .SETTLE_FRAMES(0), .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(8), .DS_SHIFT(2)
    ) dut0 (
        .clk_pixel(clk_pixel), .rst(rst), .start_in(start_in), .abort_in(abort_in),
        .pattern_ack_in(pattern_ack_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .new_frame_in(new_frame_in), .detect_0(detect_0), .detect_1(detect_1),
        .rd_addr_in(rd_addr_in), .rd_req_in(rd_req_in),
        .pattern_req_out(z_pattern_req), .bit_index_out(z_bit_index),
        .state_out(z_state), .busy_out(z_busy), .done_out(z_done),
        .result_ready_out(z_result_ready), .conflict_count_out(z_conflict_count),
        .rd_data_out(z_rd_data), .rd_pix_valid_out(z_rd_pix_valid),
        .rd_valid_out(z_rd_valid)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic set_blank();
        hcount_in    = 11'd16;
        vcount_in    = 10'd8;
        new_frame_in = 1'b0;
        detect_0     = 1'b1;
        detect_1     = 1'b1;
    endtask

    // Addr 5 sees 1,0,1 over the passes, every other pixel 0,1,1; addr 2 may conflict in pass 0.
    function automatic logic exp_d1(input int addr, input int pass, input bit conf2);
        if (conf2 && addr == 2 && pass == 0) return 1'b1;
        if (addr == 5) return (pass != 1);
        return (pass != 0);
    endfunction

    // Single frame-start cycle at pixel (0,0) with a clean "on" decision.
    task automatic pulse_frame();
        hcount_in    = 11'd0;
        vcount_in    = 10'd0;
        new_frame_in = 1'b1;
        detect_1     = 1'b1;
        detect_0     = 1'b0;
        tick();
        set_blank();
    endtask

    // 20x10 raster; only sample points of a capture frame carry a clean pattern.
    task automatic run_frame(input bit kind, input int pass, input bit conf2, input bit spam);
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 20; h++) begin
                int  a;
                logic d1;
                hcount_in    = 11'(h);
                vcount_in    = 10'(v);
                new_frame_in = (h == 0 && v == 0);
                if (kind && h < 16 && v < 8 && h % 4 == 0 && v % 4 == 0) begin
                    a        = h / 4 + 4 * (v / 4);
                    d1       = exp_d1(a, pass, conf2);
                    detect_1 = d1;
                    detect_0 = (conf2 && a == 2 && pass == 0) ? 1'b1 : ~d1;
                end else begin
                    detect_0 = 1'b1;
                    detect_1 = 1'b1;
                end
                rd_req_in  = spam;
                rd_addr_in = 3'(h);
                tick();
                if (spam) begin
                    n_vec++;
                    if (rd_valid_out !== (v != 0 || h != 0)) begin
                        n_err++;
                        $display("FAIL rd_latency v=%0d h=%0d: rd_valid_out=%b expected %b",
                                 v, h, rd_valid_out, (v != 0 || h != 0));
                    end
                end
            end
        end
        rd_req_in = 1'b0;
        set_blank();
    endtask

    task automatic run_sweep(input bit conf2, input bit spam);
        logic [AW:0] exp_cc;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n_vec++;
            if (state_out !== 3'd1 || bit_index_out !== 2'(2 - p) || pattern_req_out !== 1'b1 ||
                (p == 0 && result_ready_out !== 1'b0)) begin
                n_err++;
                $display("FAIL sweep_req p=%0d: state=%0d bit=%0d req=%b rr=%b expected 1/%0d/1/0",
                         p, state_out, bit_index_out, pattern_req_out, result_ready_out, 2 - p);
            end
            pattern_ack_in = 1'b1;
            tick();
            pattern_ack_in = 1'b0;
            n_vec++;
            if (state_out !== 3'd2) begin
                n_err++;
                $display("FAIL sweep_settle p=%0d: state=%0d expected 2", p, state_out);
            end
            run_frame(1'b0, p, conf2, 1'b0);
            run_frame(1'b1, p, conf2, spam);
            n_vec++;
            if (state_out !== 3'd3) begin
                n_err++;
                $display("FAIL sweep_capture p=%0d: state=%0d expected 3", p, state_out);
            end
            pulse_frame();
            exp_cc = (conf2 && p == 0) ? 4'd1 : 4'd0;
            n_vec++;
            if (conflict_count_out !== exp_cc) begin
                n_err++;
                $display("FAIL conflict_count p=%0d: got %0d expected %0d", p, conflict_count_out, exp_cc);
            end
            n_vec++;
            if (p < 2 && (done_out !== 1'b0 || state_out !== 3'd1)) begin
                n_err++;
                $display("FAIL pass_end p=%0d: done=%b state=%0d expected 0/1", p, done_out, state_out);
            end else if (p == 2 && (done_out !== 1'b1 || result_ready_out !== 1'b1 ||
                                    state_out !== 3'd0 || busy_out !== 1'b0)) begin
                n_err++;
                $display("FAIL sweep_done: done=%b rr=%b state=%0d busy=%b expected 1/1/0/0",
                         done_out, result_ready_out, state_out, busy_out);
            end
        end
        tick();
        n_vec++;
        if (done_out !== 1'b0 || result_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: done=%b rr=%b expected 0/1", done_out, result_ready_out);
        end
    endtask

    // Back-to-back reads of every address; each answer lands two cycles after its request.
    task automatic read_all(input bit conf2);
        logic [3:0] exp_w;
        for (int i = 0; i < 10; i++) begin
            rd_req_in  = (i < 8);
            rd_addr_in = 3'(i % 8);
            tick();
            n_vec++;
            if (i >= 1 && i <= 8) begin
                exp_w = (i - 1 == 5) ? 4'b1101 : (conf2 && i - 1 == 2) ? 4'b0111 : 4'b1011;
                if (rd_valid_out !== 1'b1 || {rd_pix_valid_out, rd_data_out} !== exp_w) begin
                    n_err++;
                    $display("FAIL read addr=%0d: valid=%b word=%b expected 1/%b",
                             i - 1, rd_valid_out, {rd_pix_valid_out, rd_data_out}, exp_w);
                end
            end else if (rd_valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL read_idle i=%0d: rd_valid_out=%b expected 0", i, rd_valid_out);
            end
        end
        rd_req_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        obs = {state_out, bit_index_out, busy_out, pattern_req_out, done_out, result_ready_out,
               conflict_count_out, rd_valid_out, rd_pix_valid_out, rd_data_out};
        n_vec++;
        if (obs !== 18'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_handshake_settle();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 50; i++) begin
            new_frame_in = (i == 25);
            tick();
        end
        new_frame_in = 1'b0;
        n_vec++;
        if (state_out !== 3'd1 || pattern_req_out !== 1'b1 || bit_index_out !== 2'd2 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL ack_wait: state=%0d req=%b bit=%0d busy=%b expected 1/1/2/1",
                     state_out, pattern_req_out, bit_index_out, busy_out);
        end
        pattern_ack_in = 1'b1;
        tick();
        pattern_ack_in = 1'b0;
        n_vec++;
        if (state_out !== 3'd2 || z_state !== 3'd2 || pattern_req_out !== 1'b0) begin
            n_err++;
            $display("FAIL after_ack: state=%0d state0=%0d req=%b expected 2/2/0",
                     state_out, z_state, pattern_req_out);
        end
        pulse_frame();
        n_vec++;
        if (state_out !== 3'd2 || z_state !== 3'd3) begin
            n_err++;
            $display("FAIL first_frame: state=%0d state0=%0d expected 2/3", state_out, z_state);
        end
        pulse_frame();
        n_vec++;
        if (state_out !== 3'd3 || z_state !== 3'd1 || z_bit_index !== 2'd1) begin
            n_err++;
            $display("FAIL second_frame: state=%0d state0=%0d bit0=%0d expected 3/1/1",
                     state_out, z_state, z_bit_index);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        n_vec++;
        if (state_out !== 3'd0 || z_state !== 3'd0 || done_out !== 1'b0 || result_ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL handshake_abort: state=%0d state0=%0d done=%b rr=%b expected 0/0/0/0",
                     state_out, z_state, done_out, result_ready_out);
        end
    endtask

    task automatic test_abort();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        pattern_ack_in = 1'b1;
        tick();
        pattern_ack_in = 1'b0;
        run_frame(1'b0, 0, 1'b0, 1'b0);
        run_frame(1'b1, 0, 1'b0, 1'b0);
        pulse_frame();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        n_vec++;
        if (state_out !== 3'd1 || bit_index_out !== 2'd1) begin
            n_err++;
            $display("FAIL busy_start: state=%0d bit=%0d expected 1/1", state_out, bit_index_out);
        end
        pattern_ack_in = 1'b1;
        tick();
        pattern_ack_in = 1'b0;
        run_frame(1'b0, 1, 1'b0, 1'b0);
        pulse_frame();
        n_vec++;
        if (state_out !== 3'd3) begin
            n_err++;
            $display("FAIL abort_setup: state=%0d expected 3", state_out);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        n_vec++;
        if (state_out !== 3'd0 || done_out !== 1'b0 || result_ready_out !== 1'b0 ||
            busy_out !== 1'b0 || pattern_req_out !== 1'b0) begin
            n_err++;
            $display("FAIL abort: state=%0d done=%b rr=%b busy=%b req=%b expected all 0",
                     state_out, done_out, result_ready_out, busy_out, pattern_req_out);
        end
        run_sweep(1'b0, 1'b0);
        read_all(1'b0);
    endtask

    task automatic test_reset_mid_settle();
        logic [17:0] obs;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        pattern_ack_in = 1'b1;
        tick();
        pattern_ack_in = 1'b0;
        pulse_frame();
        rd_addr_in = 3'd5;
        rd_req_in  = 1'b1;
        tick();
        tick();
        n_vec++;
        if (state_out !== 3'd2 || rd_valid_out !== 1'b1 || rd_data_out !== 3'b101) begin
            n_err++;
            $display("FAIL pre_reset: state=%0d rd_valid=%b rd_data=%b expected 2/1/101",
                     state_out, rd_valid_out, rd_data_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_req_in = 1'b0;
        obs = {state_out, bit_index_out, busy_out, pattern_req_out, done_out, result_ready_out,
               conflict_count_out, rd_valid_out, rd_pix_valid_out, rd_data_out};
        n_vec++;
        if (obs !== 18'd0) begin
            n_err++;
            $display("FAIL reset_mid_settle: got %h expected 0", obs);
        end
        pulse_frame();
        tick();
        n_vec++;
        if (state_out !== 3'd0 || done_out !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: state=%0d done=%b expected 0/0", state_out, done_out);
        end
    endtask

    initial begin
        set_blank();
        test_reset();
        test_handshake_settle();
        run_sweep(1'b0, 1'b0);
        read_all(1'b0);
        run_sweep(1'b1, 1'b0);
        read_all(1'b1);
        run_sweep(1'b0, 1'b1);
        read_all(1'b0);
        test_abort();
        test_reset_mid_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
